// File: rtl/uart_txq.sv
// rtl/uart_txq.sv - byte FIFO and trmt/tx_done handshake driver feeding the UART transmitter.
// Optional sticky overflow flag: define UART_TXQ_OVF_FLAG_EN.
module uart_txq #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          trmt,
   output logic [7:0]    tx_data,
   input  logic          tx_done,
   output logic          busy
`ifdef UART_TXQ_OVF_FLAG_EN
   ,
   input  logic          ovf_clr,
   output logic          ovf
`endif
);

   typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, push;

   // Flags decode the registered count only, so a push is seen by the pop logic one cycle later.
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign busy  = (state != IDLE);
   assign push  = wr_en && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      trmt      = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            trmt      = 1'b1;
            state_nxt = HOLD;
         end
         // The transmitter still shows the previous byte's tx_done here.
         HOLD: state_nxt = WAIT;
         WAIT: if (tx_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tx_data <= 8'h00;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            tx_data <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef UART_TXQ_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                      ovf <= 1'b0;
      else if (wr_en && full && !pop)  ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
   end
`endif

endmodule
